// File: rtl/cmem_seq.sv
// Coefficient-memory sequencer for the FIR core: serial coefficient load into cmem
// and the 8-lane parallel read-address pattern for one output sample.
//
// state  | meaning
// IDLE   | no access, cmem deselected; waits for load_start / run_start
// LOAD   | coef_ready high; each accepted coefficient becomes one cmem write
// RUN    | one read per cycle, lane i at address i*STEPS + step
module cmem_seq #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int NTAPS = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_start,
    input  logic            coef_valid,
    input  logic [DW-1:0]   coef_data,
    output logic            coef_ready,
    output logic            load_done,
    input  logic            run_start,
    output logic            busy,
    output logic            overrun,
    output logic            rd_valid,
    output logic [AW-1:0]   rd_step,
    output logic            rd_first,
    output logic            rd_last,
    output logic [8*AW-1:0] cmem_a,
    output logic [DW-1:0]   cmem_d,
    output logic            cmem_wen,
    output logic            cmem_cen
);

    localparam int STEPS = NTAPS / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]      state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   step;
    logic            p1_valid;
    logic [AW-1:0]   p1_step;
    logic [8*AW-1:0] run_addr;
    logic            accept;

    assign accept = (state == S_LOAD) && coef_valid && coef_ready;

    always_comb begin
        run_addr = '0;
        for (int i = 0; i < 8; i++)
            run_addr[i*AW +: AW] = AW'(i * STEPS) + step;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            step       <= '0;
            p1_valid   <= 1'b0;
            p1_step    <= '0;
            coef_ready <= 1'b0;
            load_done  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_step    <= '0;
            rd_first   <= 1'b0;
            rd_last    <= 1'b0;
            cmem_a     <= '0;
            cmem_d     <= '0;
            cmem_wen   <= 1'b1;
            cmem_cen   <= 1'b1;
        end else begin
            load_done <= 1'b0;
            cmem_cen  <= 1'b1;
            cmem_wen  <= 1'b1;
            cmem_d    <= '0;
            p1_valid  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state      <= S_LOAD;
                        wr_ptr     <= '0;
                        coef_ready <= 1'b1;
                        busy       <= 1'b1;
                    end else if (run_start) begin
                        state <= S_RUN;
                        step  <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_start || run_start)
                        overrun <= 1'b1;
                    if (accept) begin
                        cmem_cen <= 1'b0;
                        cmem_wen <= 1'b0;
                        cmem_d   <= coef_data;
                        cmem_a   <= {8{wr_ptr}};
                        if (wr_ptr == AW'(NTAPS - 1)) begin
                            coef_ready <= 1'b0;
                            load_done  <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (load_start || run_start)
                        overrun <= 1'b1;
                    cmem_cen <= 1'b0;
                    cmem_a   <= run_addr;
                    p1_valid <= 1'b1;
                    p1_step  <= step;
                    if (step == AW'(STEPS - 1)) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    coef_ready <= 1'b0;
                end
            endcase

            // second stage: cmem Q is valid the cycle after the address is sampled
            rd_valid <= p1_valid;
            rd_step  <= p1_step;
            rd_first <= p1_valid && (p1_step == '0);
            rd_last  <= p1_valid && (p1_step == AW'(STEPS - 1));
        end
    end

endmodule

// File: tb/tb_cmem_seq.sv
// Bench for cmem_seq: behavioural 8-read-port cmem plus write/read scoreboards.
module tb_cmem_seq;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int NTAPS = 64;
    localparam int STEPS = NTAPS / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_start = 1'b0;
    logic coef_valid = 1'b0;
    logic run_start  = 1'b0;
    logic [DW-1:0] coef_data = '0;
    logic coef_ready, load_done, busy, overrun;
    logic rd_valid, rd_first, rd_last;
    logic [AW-1:0] rd_step;
    logic [8*AW-1:0] cmem_a;
    logic [DW-1:0] cmem_d;
    logic cmem_wen, cmem_cen;

    always #5 clk = ~clk;

    cmem_seq #(.AW(AW), .DW(DW), .NTAPS(NTAPS)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .coef_valid(coef_valid), .coef_data(coef_data),
        .coef_ready(coef_ready), .load_done(load_done), .run_start(run_start),
        .busy(busy), .overrun(overrun), .rd_valid(rd_valid), .rd_step(rd_step),
        .rd_first(rd_first), .rd_last(rd_last), .cmem_a(cmem_a), .cmem_d(cmem_d),
        .cmem_wen(cmem_wen), .cmem_cen(cmem_cen)
    );

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct packed { logic [AW-1:0] step; logic [8*DW-1:0] data; } rd_t;

    wr_t wq[$];
    rd_t rq[$];
    wr_t we;
    rd_t re;
    int  rises[$];

    logic [DW-1:0]   mem [0:255];
    logic [8*DW-1:0] q;
    logic [DW-1:0]   exp_mem [0:NTAPS-1];

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int d0;
    logic prev_rv = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // cmem: address/controls sampled on the rising edge, Q held between reads
    always @(posedge clk) begin
        if (cmem_cen === 1'b0) begin
            if (cmem_wen === 1'b0)
                mem[cmem_a[AW-1:0]] <= cmem_d;
            else
                for (int i = 0; i < 8; i++)
                    q[i*DW +: DW] <= mem[cmem_a[i*AW +: AW]];
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (cmem_cen === 1'b0 && cmem_wen === 1'b0) begin
            wr_cnt++;
            if (wq.size() == 0)
                check("wr_unexpected", cmem_wen, 1'b1);
            else begin
                we = wq.pop_front();
                check("wr_addr", cmem_a, {8{we.addr}});
                check("wr_data", cmem_d, we.data);
            end
        end
        if (cmem_cen === 1'b0 && cmem_wen === 1'b1)
            check("rd_d_zero", cmem_d, 0);
        if (load_done === 1'b1) begin
            done_cnt++;
            check("done_on_last_wr", {cmem_cen, cmem_wen, cmem_a[AW-1:0]},
                  {2'b00, AW'(NTAPS - 1)});
        end
        if (rd_valid === 1'b1) begin
            if (rq.size() == 0)
                check("rd_unexpected", rd_valid, 1'b0);
            else begin
                re = rq.pop_front();
                check("rd_step", rd_step, re.step);
                check("rd_first", rd_first, re.step == 0);
                check("rd_last", rd_last, re.step == AW'(STEPS - 1));
                check("rd_data", q, re.data);
            end
            if (prev_rv !== 1'b1)
                rises.push_back(cyc);
        end
        prev_rv = rd_valid;
    end

    task automatic do_load(input int n, input int seed, input bit with_run);
        int c = 0;
        int j = 0;
        wr_t w;
        load_start = 1'b1;
        run_start  = with_run;
        tick;
        load_start = 1'b0;
        run_start  = 1'b0;
        check("busy_in_load", busy, 1'b1);
        while (j < n) begin
            c++;
            if (c % 3 == 0) begin
                coef_valid = 1'b0;
                coef_data  = DW'($urandom);
            end else begin
                coef_valid = 1'b1;
                coef_data  = DW'(j * 131 + seed);
                check("coef_ready", coef_ready, 1'b1);
                w.addr = AW'(j);
                w.data = coef_data;
                wq.push_back(w);
                exp_mem[j] = coef_data;
                j++;
            end
            tick;
        end
        coef_valid = 1'b0;
    endtask

    task automatic do_run(input int n);
        rd_t r;
        for (int s = 0; s < n; s++) begin
            r.step = AW'(s);
            for (int i = 0; i < 8; i++)
                r.data[i*DW +: DW] = exp_mem[i*STEPS + s];
            rq.push_back(r);
        end
        run_start = 1'b1;
        tick;
        run_start = 1'b0;
    endtask

    initial begin
        // reset with random inputs
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            load_start = 1'($urandom);
            run_start  = 1'($urandom);
            coef_valid = 1'($urandom);
            coef_data  = DW'($urandom);
            tick;
        end
        check("rst_outputs",
              {coef_ready, load_done, busy, overrun, rd_valid, rd_first, rd_last, cmem_wen, cmem_cen},
              9'b000000011);
        check("rst_rd_step", rd_step, 0);
        check("rst_cmem_a", cmem_a, 0);
        check("rst_cmem_d", cmem_d, 0);
        load_start = 1'b0; run_start = 1'b0; coef_valid = 1'b0;
        rst = 1'b0;
        tick;

        // coef_valid in IDLE is ignored
        coef_valid = 1'b1;
        repeat (3) tick;
        check("idle_coef_ready", coef_ready, 1'b0);
        coef_valid = 1'b0;

        // full load with a gap every third cycle
        do_load(NTAPS, 7, 1'b0);
        check("ready_drop", coef_ready, 1'b0);
        tick;
        check("busy_after_load", busy, 1'b0);
        check("done_single", load_done, 1'b0);
        repeat (3) tick;
        check("done_cnt_a", done_cnt, 1);
        check("wr_cnt_a", wr_cnt, NTAPS);
        check("wq_empty_a", wq.size(), 0);

        // run latency and pattern
        do_run(STEPS);
        check("busy_run", busy, 1'b1);
        check("rv_lat0", rd_valid, 1'b0);
        tick;
        check("rv_lat1", rd_valid, 1'b0);
        tick;
        check("rv_lat2", rd_valid, 1'b1);
        check("rv_first", rd_first, 1'b1);
        repeat (12) tick;
        check("rq_empty_run", rq.size(), 0);

        // back-to-back runs
        rises.delete();
        do_run(STEPS);
        repeat (STEPS) tick;
        check("busy_first_idle", busy, 1'b0);
        do_run(STEPS);
        repeat (14) tick;
        check("b2b_seqs", rises.size(), 2);
        if (rises.size() == 2)
            check("b2b_gap", rises[1] - rises[0], STEPS + 1);
        check("rq_empty_b2b", rq.size(), 0);

        // run_start during RUN
        check("overrun_clear", overrun, 1'b0);
        do_run(STEPS);
        run_start = 1'b1;
        tick;
        run_start = 1'b0;
        check("overrun_set", overrun, 1'b1);
        repeat (15) tick;
        check("overrun_sticky", overrun, 1'b1);
        check("rq_empty_ovr", rq.size(), 0);

        // reset at step 3 of RUN
        do_run(2);
        repeat (3) tick;
        rst = 1'b1;
        tick;
        check("midrun_rd_valid", rd_valid, 1'b0);
        check("midrun_cen", {cmem_cen, cmem_wen}, 2'b11);
        check("midrun_busy", busy, 1'b0);
        check("midrun_overrun", overrun, 1'b0);
        rst = 1'b0;
        repeat (10) tick;
        check("rq_empty_midrun", rq.size(), 0);

        // reset after 20 accepts of a load
        d0 = done_cnt;
        do_load(20, 300, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midload_ready", coef_ready, 1'b0);
        check("midload_busy", busy, 1'b0);
        repeat (3) tick;
        check("midload_no_done", done_cnt, d0);
        check("wq_empty_midload", wq.size(), 0);

        // load_start and run_start together: fresh load wins
        do_load(NTAPS, 1234, 1'b1);
        repeat (4) tick;
        check("coll_done", done_cnt, d0 + 1);
        check("coll_overrun", overrun, 1'b0);
        check("wq_empty_b", wq.size(), 0);
        check("rq_empty_coll", rq.size(), 0);

        do_run(STEPS);
        repeat (14) tick;
        check("rq_empty_b", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/cmem_seq.md
Name: cmem_seq

Overview:
Controller that sequences the 8-read-port coefficient memory (cmem) of the FIR core. In LOAD mode it accepts a valid/ready coefficient stream and issues serial writes. In RUN mode it issues the parallel 8-lane read address pattern for one output sample, and flags when the Q7..Q0 data is valid for the MAC datapath. It sits between the host/config interface and cmem, and drives every cmem control and address pin.

Parameters:
AW, 8, cmem address width per port
DW, 16, coefficient width (cmem D/Q width)
NTAPS, 64, total coefficients; must be a multiple of 8 and at most 2**AW
STEPS, NTAPS/8, derived (localparam): read steps per sample, one tap per lane per step

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active high
load_start  in  1  pulse: begin coefficient load (accepted only in IDLE)
coef_valid  in  1  coefficient stream valid
coef_data  in  DW  coefficient value
coef_ready  out  1  controller accepts a coefficient this cycle
load_done  out  1  1-cycle pulse when the final write is presented to cmem
run_start  in  1  pulse: begin one sample's read sequence (accepted only in IDLE)
busy  out  1  high in LOAD or RUN
overrun  out  1  sticky; set by run_start or load_start arriving while not IDLE; cleared by rst
rd_valid  out  1  cmem Q7..Q0 hold the taps of step rd_step this cycle
rd_step  out  AW  step index for the current rd_valid
rd_first  out  1  rd_valid and rd_step==0
rd_last  out  1  rd_valid and rd_step==STEPS-1
cmem_a  out  8*AW  lane i address on bits [i*AW +: AW]; maps to cmem A0..A7
cmem_d  out  DW  cmem write data (D)
cmem_wen  out  1  cmem write enable, active low
cmem_cen  out  1  cmem chip enable, active low

Behaviour:
- All outputs are registered. Reset values: coef_ready=0, load_done=0, busy=0, overrun=0, rd_valid=0, rd_step=0, rd_first=0, rd_last=0, cmem_a=0, cmem_d=0, cmem_wen=1, cmem_cen=1. State resets to IDLE and all counters to 0.
- States: IDLE, LOAD, RUN.
- IDLE:
  - load_start has priority over run_start.
  - load_start -> LOAD; wr_ptr=0; coef_ready=1 from the next cycle.
  - run_start (without load_start) -> RUN; step=0.
  - cmem_cen=1, cmem_wen=1.
- LOAD:
  - An accept is coef_valid && coef_ready.
  - On an accept, the next cycle presents: cmem_cen=0, cmem_wen=0, cmem_d=coef_data, and wr_ptr on all 8 lanes of cmem_a (A0 is the write address). wr_ptr then increments.
  - With no accept, the next cycle has cmem_cen=1 and cmem_wen=1 (stall with no write). A stall of any length is legal.
  - On accept number NTAPS (wr_ptr==NTAPS-1): coef_ready drops to 0 next cycle, load_done pulses in the same cycle the final write is presented, and state -> IDLE.
  - Coefficient j is stored at address j.
- RUN:
  - Each cycle at step s, the next cycle presents cmem_cen=0, cmem_wen=1, cmem_d=0, and lane i address = i*STEPS + s.
  - After step STEPS-1, state -> IDLE. Exactly STEPS consecutive read cycles, with no bubbles.
- Read latency: cmem samples the address at the edge ending its presentation cycle. rd_valid, rd_step, rd_first and rd_last therefore assert 2 cycles after the controller's RUN cycle for that step, through a 2-stage pipeline.
- The pipeline drains after returning to IDLE. busy covers only LOAD/RUN, not the drain.
- A new run_start is legal in the first IDLE cycle; back-to-back samples produce a 1-cycle gap in rd_valid.
- run_start or load_start in LOAD/RUN is ignored and sets overrun.
- coef_valid outside LOAD is ignored.
- rst mid-LOAD or mid-RUN:
  - Immediate return to IDLE with reset output values next cycle.
  - The rd_valid pipeline is flushed.
  - Partially loaded coefficients remain in cmem, but load_done never pulses for the aborted load.
- Counters are wide enough for NTAPS-1; no wrap is possible within a legal operation.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all outputs at reset values; cmem_cen=1, cmem_wen=1.
- Load with gaps: load_start, then 64 coefficients with coef_valid low on every 3rd cycle -> exactly 64 write cycles at addresses 0..63 with matching data; load_done pulses once, on the address-63 write; busy falls next cycle.
- Run pattern: after the load, run_start -> 8 read cycles; at step s, lane i address = i*8+s (step 0: 0,8,16,...,56; step 7: 7,15,...,63); rd_valid high for 8 cycles starting 3 cycles after run_start; rd_first at step 0, rd_last at step 7. Data check against the loaded values through cmem.
- Collisions: load_start and run_start in the same IDLE cycle -> LOAD entered, no reads. run_start during RUN -> ignored, overrun=1 and it stays 1.
- Reset mid-operation: rst asserted at step 3 of RUN -> next cycle rd_valid=0 and cmem_cen=1; no further rd_valid. rst after 20 accepts of a load -> no load_done; a fresh load then completes normally.
- Back-to-back runs: run_start on the first IDLE cycle after a run -> second sequence of 8 steps; rd_valid shows one idle cycle between the two sequences.
